// File: rtl/spi_mmio_bridge.sv
// SPI mode-0 slave that turns {RW, A[6:0]} + data-byte frames into single-cycle
// 8-bit MMIO reads/writes. All SPI lines are oversampled in the clk domain.
module spi_mmio_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       bus_cs,
  output logic       bus_rd,
  output logic       bus_wr,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic                   sclk_prev_r, cs_prev_r;
  logic                   sclk_s, cs_n_s, mosi_s;
  logic                   sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
  logic [7:0]             rx_byte_s;

  state_t     state_r, state_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [6:0] rx_r, rx_nxt_s;
  logic [7:0] tx_r, tx_nxt_s;
  logic       rw_r, rw_nxt_s;
  logic [6:0] addr_q_r, addr_q_nxt_s;
  logic       rd_pend_r, rd_pend_nxt_s;
  logic       oe_r, oe_nxt_s;
  logic       bus_cs_r, bus_cs_nxt_s;
  logic       bus_rd_r, bus_rd_nxt_s;
  logic       bus_wr_r, bus_wr_nxt_s;
  logic [7:0] bus_addr_r, bus_addr_nxt_s;
  logic [7:0] bus_wdata_r, bus_wdata_nxt_s;
  logic       frame_err_r, frame_err_nxt_s;

  // Synchronisers and previous-sample registers for edge detection.
  // CS_n resets to "asserted" so a CS_n held low through reset release never looks like a new falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync_r[SYNC_STAGES-1];
  assign cs_n_s     = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sclk_s & ~sclk_prev_r;
  assign sck_fall_s = ~sclk_s & sclk_prev_r;
  assign cs_fall_s  = ~cs_n_s & cs_prev_r;
  assign cs_rise_s  = cs_n_s & ~cs_prev_r;
  assign rx_byte_s  = {rx_r, mosi_s};

  // Frame FSM next-state, shift registers and bus-cycle generation.
  always_comb begin
    state_nxt_s     = state_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    rx_nxt_s        = rx_r;
    tx_nxt_s        = bus_rd_r ? bus_rdata : tx_r;
    rw_nxt_s        = rw_r;
    addr_q_nxt_s    = addr_q_r;
    rd_pend_nxt_s   = 1'b0;
    oe_nxt_s        = oe_r;
    bus_cs_nxt_s    = 1'b0;
    bus_rd_nxt_s    = 1'b0;
    bus_wr_nxt_s    = 1'b0;
    bus_addr_nxt_s  = bus_addr_r;
    bus_wdata_nxt_s = bus_wdata_r;
    frame_err_nxt_s = 1'b0;

    // A prefetch read belongs to an already completed byte, so it is issued even if CS_n rises now.
    if (rd_pend_r) begin
      bus_cs_nxt_s   = 1'b1;
      bus_rd_nxt_s   = 1'b1;
      bus_addr_nxt_s = {1'b0, addr_q_r};
    end else begin
      bus_cs_nxt_s   = 1'b0;
      bus_rd_nxt_s   = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s   = ST_CMD;
          bit_cnt_nxt_s = 3'd0;
          oe_nxt_s      = 1'b1;
          tx_nxt_s      = 8'h00;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_CMD, ST_DATA: begin
        if (cs_rise_s) begin
          state_nxt_s     = ST_IDLE;
          oe_nxt_s        = 1'b0;
          bit_cnt_nxt_s   = 3'd0;
          frame_err_nxt_s = (bit_cnt_r != 3'd0);
        end else if (sck_rise_s) begin
          rx_nxt_s      = rx_byte_s[6:0];
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            if (state_r == ST_CMD) begin
              rw_nxt_s     = rx_byte_s[7];
              addr_q_nxt_s = rx_byte_s[6:0];
              state_nxt_s  = ST_DATA;
              if (rx_byte_s[7]) begin
                bus_cs_nxt_s   = 1'b1;
                bus_rd_nxt_s   = 1'b1;
                bus_addr_nxt_s = {1'b0, rx_byte_s[6:0]};
              end else begin
                bus_rd_nxt_s   = bus_rd_nxt_s;
              end
            end else if (rw_r) begin
              addr_q_nxt_s  = (AUTO_INC != 0) ? addr_q_r + 7'd1 : addr_q_r;
              rd_pend_nxt_s = 1'b1;
            end else begin
              bus_cs_nxt_s    = 1'b1;
              bus_wr_nxt_s    = 1'b1;
              bus_addr_nxt_s  = {1'b0, addr_q_r};
              bus_wdata_nxt_s = rx_byte_s;
              addr_q_nxt_s    = (AUTO_INC != 0) ? addr_q_r + 7'd1 : addr_q_r;
            end
          end else begin
            rw_nxt_s = rw_r;
          end
        end else if (sck_fall_s) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB on MISO.
          tx_nxt_s = (bit_cnt_r != 3'd0) ? {tx_r[6:0], 1'b0} : tx_nxt_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        oe_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      rx_r        <= 7'd0;
      tx_r        <= 8'h00;
      rw_r        <= 1'b0;
      addr_q_r    <= 7'd0;
      rd_pend_r   <= 1'b0;
      oe_r        <= 1'b0;
      bus_cs_r    <= 1'b0;
      bus_rd_r    <= 1'b0;
      bus_wr_r    <= 1'b0;
      bus_addr_r  <= 8'h00;
      bus_wdata_r <= 8'h00;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      rx_r        <= rx_nxt_s;
      tx_r        <= tx_nxt_s;
      rw_r        <= rw_nxt_s;
      addr_q_r    <= addr_q_nxt_s;
      rd_pend_r   <= rd_pend_nxt_s;
      oe_r        <= oe_nxt_s;
      bus_cs_r    <= bus_cs_nxt_s;
      bus_rd_r    <= bus_rd_nxt_s;
      bus_wr_r    <= bus_wr_nxt_s;
      bus_addr_r  <= bus_addr_nxt_s;
      bus_wdata_r <= bus_wdata_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  assign spi_miso    = oe_r & tx_r[7];
  assign spi_miso_oe = oe_r;
  assign bus_cs      = bus_cs_r;
  assign bus_rd      = bus_rd_r;
  assign bus_wr      = bus_wr_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign frame_err   = frame_err_r;

endmodule

// File: doc/spi_mmio_bridge.md
Name: spi_mmio_bridge

Overview:
- SPI slave front-end that turns MCU SPI frames into single-cycle 8-bit MMIO bus cycles on the coprocessor register shadow.
- Drives cs/rd/wr/addr/wdata and samples rdata, so the register map, including CTRL START/INIT pulses, is reachable over 4 pins.
- SPI mode 0, MSB first. The SPI lines are oversampled in the clk domain; there is no SCK clock domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on spi_sclk, spi_cs_n and spi_mosi (minimum 2).
- AUTO_INC, 1, 1 = address increments after each data byte in a frame; 0 = address held for the whole frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_sclk  in  1  SPI clock, idle low
- spi_cs_n  in  1  SPI chip select, active low
- spi_mosi  in  1  SPI data in
- spi_miso  out  1  SPI data out
- spi_miso_oe  out  1  MISO output enable, high while the frame is active
- bus_cs  out  1  bus select, 1-cycle pulse together with bus_rd or bus_wr
- bus_rd  out  1  read strobe, 1 cycle
- bus_wr  out  1  write strobe, 1 cycle
- bus_addr  out  8  bus address; bit 7 is always 0
- bus_wdata  out  8  write data
- bus_rdata  in  8  read data, combinational, valid in the bus_rd cycle
- frame_err  out  1  1-cycle pulse when a frame is aborted mid-byte

Behaviour:
- Reset values: all outputs 0. Internal state: state=IDLE, bit_cnt=0, tx shift register=0x00.
- Synchronisation: SCK, CS_n and MOSI each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised SCK.
- SCK constraint: high and low phases must each be at least SYNC_STAGES+2 clk periods. Behaviour outside this is undefined.
- Frame format:
  - Byte 0 = {RW, A[6:0]}; RW=1 means read.
  - Bytes 1..N = data bytes.
- MOSI sampling: on each synchronised SCK rising edge, MOSI shifts into the rx register and bit_cnt increments mod 8.
- States:
  - IDLE: waiting for a frame. Synchronised CS_n falling moves to CMD; bit_cnt=0, spi_miso_oe=1, tx=0x00.
  - CMD: 8th rising edge stores rw and addr_q={0,A}, then moves to DATA.
    - If rw=1, the next clk asserts bus_cs=bus_rd=1 with bus_addr=addr_q, and tx loads bus_rdata in that same cycle.
  - DATA, write (rw=0): 8th rising edge of each data byte is followed next clk by bus_cs=bus_wr=1, bus_addr=addr_q, bus_wdata=rx byte.
    - Then, if AUTO_INC, addr_q=(addr_q+1) mod 128.
  - DATA, read (rw=1): 8th rising edge of each data byte is followed next clk by the address increment, if AUTO_INC.
    - The clk after that issues a read at the new addr_q and loads tx. This prefetches the next data byte.
- MISO timing: spi_miso=tx[7] at all times while oe=1.
  - tx shifts left (zero fill) on each SCK falling edge where bit_cnt != 0.
  - The falling edge that follows a byte boundary does not shift, so the freshly loaded MSB stays valid for the next rising edge.
  - MISO is 0 throughout the CMD byte.
- Bus pulses: every bus pulse lasts exactly 1 cycle. bus_rd and bus_wr are never high in the same cycle. bus_addr and bus_wdata hold their last values between pulses.
- CS_n deasserted (synchronised rising edge):
  - Always: return to IDLE and set oe=0.
  - If bit_cnt != 0: the partial byte is discarded, no bus cycle is issued, and frame_err pulses once.
  - If deassertion coincides with the bus-cycle clk of a completed byte, that bus cycle still completes.
- Frame with only the CMD byte:
  - Write: no bus cycle.
  - Read: one bus read is issued at A. This is harmless because reads have no side effects.
- Address wrap: 0x7F increments to 0x00.
- Asynchronous reset mid-frame: immediate return to reset values, no pending bus cycle survives. CS_n held low across reset release is ignored until it returns high and falls again.

Test Plan:
- Write frame 0x01,0x0B (SCK half-period 6 clk) -> exactly one bus_wr pulse with bus_addr=0x01, bus_wdata=0x0B; no bus_rd.
- Burst write 0x10, 0x80,0x80,0xC0,0x00 -> four bus_wr pulses, addr 0x10,0x11,0x12,0x13, data as sent; with AUTO_INC=0, all four at 0x10.
- Read frame 0x84, dummy byte, with bus_rdata model returning 0x37 at addr 0x04 -> bus_rd at 0x04 after CMD; MISO bits 0,0,1,1,0,1,1,1 on data-byte rising edges.
- Burst read 0x80 with 2 dummy bytes, model 0x00→0x01, 0x01→0x00 -> MISO bytes 0x01 then 0x00; bus_rd at 0x00 then 0x01; extra prefetch read at 0x02.
- CS_n raised after 3 bits of a write data byte -> no bus_wr, frame_err=1 for 1 cycle, MISO oe=0; next full frame 0x02,0x19 gives bus_wr addr 0x02 data 0x19.
- Write with addr 0x7F, 2 data bytes -> writes at 0x7F then 0x00. Separately, rst_n pulsed low mid-byte -> all outputs 0 immediately, no bus pulse after release.
